// File: rtl/mby_gmm_pkg.sv
// mby_gmm_pkg: shared tag ring slot type plus tag-ring injector defaults and FSM states
package mby_gmm_pkg;
  typedef struct packed {
    logic        valid;
    logic [3:0]  dst;
    logic [11:0] tag;
  } mby_tag_ring_t;
  localparam int MBY_TAGRING_NREQ_DEF = 4;
  typedef enum logic [1:0] {IDLE, WAIT, STARVED} tagring_inj_state_t;
endpackage

// File: rtl/egr_tagring_if.sv
// egr_tagring_if: one tag ring slot between adjacent ring stops
interface egr_tagring_if;
  import mby_gmm_pkg::*;
  mby_tag_ring_t slot;
  modport egr (input slot);
  modport tagring (output slot);
endinterface

// File: rtl/mby_rr_arb_n.sv
// mby_rr_arb_n: combinational round-robin one-hot picker; first request at or above ptr wins, with wrap
module mby_rr_arb_n #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] w_j;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(ptr) + k) % N);
      if (en && req[w_j]) begin
        gnt = '0;
        gnt[w_j] = 1'b1;
        gnt_idx = w_j;
      end
    end
  end
endmodule

// File: rtl/mby_egr_tagring_inj_arb.sv
// mby_egr_tagring_inj_arb: injects local tags into empty ring slots round-robin,
// with a starvation monitor that asks upstream for a bubble
module mby_egr_tagring_inj_arb
  import mby_gmm_pkg::*;
#(
  parameter int N_REQ = MBY_TAGRING_NREQ_DEF,
  parameter int CNT_W = 8,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                            cclk,
  input  logic                            rst_n,
  input  logic                            cfg_enable,
  input  logic [CNT_W-1:0]                cfg_starve_thr,
  egr_tagring_if.egr                      ring_in,
  egr_tagring_if.tagring                  ring_out,
  input  logic [N_REQ-1:0]                req_valid,
  input  mby_tag_ring_t [N_REQ-1:0]       req_tag,
  output logic [N_REQ-1:0]                req_ready,
  output logic                            bubble_req,
  output logic [CNT_W-1:0]                starve_cnt
);
  tagring_inj_state_t r_state, w_state_nxt;
  logic [IW-1:0]    r_ptr, w_gnt_idx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_bubble, w_pend, w_grant;
  mby_tag_ring_t    r_slot, w_slot_nxt, w_tag;
  mby_rr_arb_n #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .en      (cfg_enable & ~ring_in.slot.valid),
    .gnt     (req_ready),
    .gnt_idx (w_gnt_idx)
  );
  assign w_pend    = cfg_enable & |req_valid;
  assign w_grant   = |req_ready;
  assign w_cnt_inc = &r_cnt ? r_cnt : r_cnt + 1'b1;
  always_comb begin
    w_tag = req_tag[w_gnt_idx];
    w_tag.valid = 1'b1;
    w_slot_nxt = ring_in.slot.valid ? ring_in.slot : w_grant ? w_tag : '0;
  end
  // A pending request that is not granted is by construction blocked by through traffic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    if (!w_pend || w_grant) begin
      w_state_nxt = IDLE;
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = w_cnt_inc;
      w_state_nxt = (r_state == STARVED || (|cfg_starve_thr && w_cnt_inc >= cfg_starve_thr)) ? STARVED : WAIT;
    end
  end
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
      r_state <= IDLE;
      r_cnt <= '0;
      r_bubble <= 1'b0;
      r_ptr <= '0;
    end else begin
      r_slot <= w_slot_nxt;
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_bubble <= w_state_nxt == STARVED;
      if (w_grant) r_ptr <= IW'((int'(w_gnt_idx) + 1) % N_REQ);
    end
  end
  assign ring_out.slot = r_slot;
  assign bubble_req = r_bubble;
  assign starve_cnt = r_cnt;
endmodule

// File: tb/tb_mby_egr_tagring_inj_arb.sv
// tb_mby_egr_tagring_inj_arb: directed self-checking bench for the tag ring injector
module tb_mby_egr_tagring_inj_arb;
  import mby_gmm_pkg::*;
  logic                      cclk = 1'b0;
  logic                      rst_n;
  logic                      cfg_enable;
  logic [7:0]                cfg_starve_thr;
  logic [3:0]                req_valid;
  mby_tag_ring_t [3:0]       req_tag;
  logic [3:0]                req_ready;
  logic                      bubble_req;
  logic [7:0]                starve_cnt;
  int checks = 0;
  int errors = 0;
  egr_tagring_if u_in ();
  egr_tagring_if u_out ();
  mby_egr_tagring_inj_arb #(.N_REQ(4), .CNT_W(8)) dut (
    .cclk           (cclk),
    .rst_n          (rst_n),
    .cfg_enable     (cfg_enable),
    .cfg_starve_thr (cfg_starve_thr),
    .ring_in        (u_in),
    .ring_out       (u_out),
    .req_valid      (req_valid),
    .req_tag        (req_tag),
    .req_ready      (req_ready),
    .bubble_req     (bubble_req),
    .starve_cnt     (starve_cnt)
  );
  always #5 cclk = ~cclk;
  function automatic mby_tag_ring_t mk(input logic v, input logic [3:0] d, input logic [11:0] t);
    mk = {v, d, t};
  endfunction
  function automatic mby_tag_ring_t exp_tag(input int i);
    exp_tag = mk(1'b1, 4'(i), 12'(256 + i));
  endfunction
  task automatic test_reset;
    repeat (2) @(negedge cclk);
    checks++; if (u_out.slot !== '0) begin errors++; $display("FAIL reset_ring_out got %h want 0", u_out.slot); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (bubble_req !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b want 0", bubble_req); end
    checks++; if (starve_cnt !== 8'd0) begin errors++; $display("FAIL reset_starve_cnt got %0d want 0", starve_cnt); end
    rst_n = 1'b1;
  endtask
  task automatic test_passthrough;
    mby_tag_ring_t pt [3];
    pt[0] = mk(1'b1, 4'hA, 12'hAAA);
    pt[1] = mk(1'b1, 4'hB, 12'hBBB);
    pt[2] = mk(1'b1, 4'hC, 12'hCCC);
    cfg_enable = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge cclk);
      if (i > 0) begin
        checks++; if (u_out.slot !== pt[i-1]) begin errors++; $display("FAIL passthru_out%0d got %h want %h", i - 1, u_out.slot, pt[i-1]); end
      end
      u_in.slot = (i < 3) ? pt[i] : '0;
      #1;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL passthru_ready%0d got %b want 0000", i, req_ready); end
    end
    req_valid = 4'b0;
  endtask
  task automatic test_round_robin;
    cfg_enable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge cclk);
      if (c > 0) begin
        checks++; if (u_out.slot !== exp_tag((c - 1) % 4)) begin errors++; $display("FAIL rr_out%0d got %h want %h", c - 1, u_out.slot, exp_tag((c - 1) % 4)); end
      end
      req_valid = 4'b1111;
      #1;
      checks++; if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_grant%0d got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
    end
    @(negedge cclk);
    checks++; if (u_out.slot !== exp_tag(3)) begin errors++; $display("FAIL rr_out7 got %h want %h", u_out.slot, exp_tag(3)); end
    req_valid = 4'b0;
  endtask
  task automatic test_sparse_rr;
    logic [3:0] exp_g [3];
    int exp_i [3];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010;
    exp_i[0] = 1; exp_i[1] = 3; exp_i[2] = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge cclk);
      if (c > 0) begin
        checks++; if (u_out.slot !== exp_tag(exp_i[c-1])) begin errors++; $display("FAIL sparse_out%0d got %h want %h", c - 1, u_out.slot, exp_tag(exp_i[c-1])); end
      end
      req_valid = (c < 3) ? 4'b1010 : 4'b0000;
      #1;
      if (c < 3) begin
        checks++; if (req_ready !== exp_g[c]) begin errors++; $display("FAIL sparse_grant%0d got %b want %b", c, req_ready, exp_g[c]); end
      end
    end
  endtask
  task automatic test_starvation;
    cfg_starve_thr = 8'd5;
    for (int k = 1; k <= 10; k++) begin
      @(negedge cclk);
      if (k > 1) begin
        checks++; if (u_out.slot !== mk(1'b1, 4'h2, 12'(512 + k - 1))) begin errors++; $display("FAIL starve_pass%0d got %h want %h", k - 1, u_out.slot, mk(1'b1, 4'h2, 12'(512 + k - 1))); end
        checks++; if (starve_cnt !== 8'(k - 1)) begin errors++; $display("FAIL starve_cnt%0d got %0d want %0d", k - 1, starve_cnt, k - 1); end
        checks++; if (bubble_req !== (k - 1 >= 5)) begin errors++; $display("FAIL starve_bubble%0d got %b want %b", k - 1, bubble_req, k - 1 >= 5); end
      end
      u_in.slot = mk(1'b1, 4'h2, 12'(512 + k));
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL starve_ready%0d got %b want 0000", k, req_ready); end
    end
    @(negedge cclk);
    checks++; if (starve_cnt !== 8'd10) begin errors++; $display("FAIL starve_cnt10 got %0d want 10", starve_cnt); end
    checks++; if (bubble_req !== 1'b1) begin errors++; $display("FAIL starve_bubble10 got %b want 1", bubble_req); end
    u_in.slot = '0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL starve_grant got %b want 0100", req_ready); end
    @(negedge cclk);
    req_valid = 4'b0;
    checks++; if (u_out.slot !== exp_tag(2)) begin errors++; $display("FAIL starve_grant_out got %h want %h", u_out.slot, exp_tag(2)); end
    checks++; if (bubble_req !== 1'b0) begin errors++; $display("FAIL starve_bubble_fall got %b want 0", bubble_req); end
    checks++; if (starve_cnt !== 8'd0) begin errors++; $display("FAIL starve_cnt_clear got %0d want 0", starve_cnt); end
  endtask
  task automatic test_thr_zero;
    logic bub_seen = 1'b0;
    cfg_starve_thr = 8'd0;
    for (int k = 0; k < 300; k++) begin
      @(negedge cclk);
      if (bubble_req) bub_seen = 1'b1;
      u_in.slot = mk(1'b1, 4'h3, 12'(k));
      req_valid = 4'b0001;
    end
    @(negedge cclk);
    if (bubble_req) bub_seen = 1'b1;
    checks++; if (starve_cnt !== 8'd255) begin errors++; $display("FAIL thr0_saturate got %0d want 255", starve_cnt); end
    checks++; if (bub_seen !== 1'b0) begin errors++; $display("FAIL thr0_bubble got %b want 0", bub_seen); end
    u_in.slot = '0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL thr0_grant got %b want 0001", req_ready); end
    @(negedge cclk);
    req_valid = 4'b0;
    checks++; if (starve_cnt !== 8'd0) begin errors++; $display("FAIL thr0_cnt_clear got %0d want 0", starve_cnt); end
  endtask
  task automatic test_disable;
    cfg_starve_thr = 8'd2;
    u_in.slot = mk(1'b1, 4'h4, 12'h444);
    req_valid = 4'b0001;
    repeat (3) @(negedge cclk);
    checks++; if (starve_cnt !== 8'd3) begin errors++; $display("FAIL dis_cnt got %0d want 3", starve_cnt); end
    checks++; if (bubble_req !== 1'b1) begin errors++; $display("FAIL dis_bubble_on got %b want 1", bubble_req); end
    cfg_enable = 1'b0;
    @(negedge cclk);
    checks++; if (starve_cnt !== 8'd0) begin errors++; $display("FAIL dis_cnt_clear got %0d want 0", starve_cnt); end
    checks++; if (bubble_req !== 1'b0) begin errors++; $display("FAIL dis_bubble_off got %b want 0", bubble_req); end
    u_in.slot = '0;
    req_valid = 4'b0;
  endtask
  task automatic test_reset_mid;
    cfg_enable = 1'b1;
    @(negedge cclk);
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_pre_grant got %b want 0010", req_ready); end
    @(negedge cclk);
    checks++; if (u_out.slot !== exp_tag(1)) begin errors++; $display("FAIL rst_pre_out got %h want %h", u_out.slot, exp_tag(1)); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (u_out.slot.valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", u_out.slot.valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr_zero got %b want 0001", req_ready); end
    @(negedge cclk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got %b want 0001", req_ready); end
    @(negedge cclk);
    req_valid = 4'b0;
    checks++; if (u_out.slot !== exp_tag(0)) begin errors++; $display("FAIL rst_first_out got %h want %h", u_out.slot, exp_tag(0)); end
  endtask
  initial begin
    rst_n = 1'b0;
    cfg_enable = 1'b0;
    cfg_starve_thr = 8'd0;
    req_valid = 4'b0;
    u_in.slot = '0;
    for (int i = 0; i < 4; i++) req_tag[i] = mk(1'(i % 2), 4'(i), 12'(256 + i));
    test_reset();
    test_passthrough();
    test_round_robin();
    test_sparse_rr();
    test_starvation();
    test_thr_zero();
    test_disable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
